// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM states,
// minterm-count helper and a saturating increment.
package tts_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  function automatic int unsigned nmint(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Increments v but never past the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/tts_err_accum.sv
// Mismatch bookkeeping for one sweep: saturating error count, first failing
// minterm and per-implementation sticky error flags.
module tts_err_accum import tts_pkg::*; #(
  parameter int N_IN  = 2,
  parameter int ERR_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             smp,
  input  logic [N_IN-1:0]  m,
  input  logic             ea,
  input  logic             eb,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_m,
  output logic             first_err_valid,
  output logic             a_err_seen,
  output logic             b_err_seen
);

  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]  first_m_q, first_m_d;
  logic             first_v_q, first_v_d;
  logic             a_seen_q, a_seen_d;
  logic             b_seen_q, b_seen_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    first_m_d = first_m_q;
    first_v_d = first_v_q;
    a_seen_d  = a_seen_q;
    b_seen_d  = b_seen_q;
    if (clear) begin
      err_cnt_d = '0;
      first_m_d = '0;
      first_v_d = 1'b0;
      a_seen_d  = 1'b0;
      b_seen_d  = 1'b0;
    end else if (smp && (ea || eb)) begin
      // One count per failing minterm, even when both implementations fail.
      err_cnt_d = ERR_W'(sat_inc(32'(err_cnt_q), ERR_W));
      if (!first_v_q) begin
        first_m_d = m;
        first_v_d = 1'b1;
      end
      a_seen_d = a_seen_q | ea;
      b_seen_d = b_seen_q | eb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      first_m_q <= '0;
      first_v_q <= 1'b0;
      a_seen_q  <= 1'b0;
      b_seen_q  <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      first_m_q <= first_m_d;
      first_v_q <= first_v_d;
      a_seen_q  <= a_seen_d;
      b_seen_q  <= b_seen_d;
    end
  end

  assign err_cnt         = err_cnt_q;
  assign first_err_m     = first_m_q;
  assign first_err_valid = first_v_q;
  assign a_err_seen      = a_seen_q;
  assign b_err_seen      = b_seen_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive sweep of a small combinational unit: drives every minterm
// on vec, samples two implementations and checks them against a latched table.
module truth_table_sweeper import tts_pkg::*; #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = N_IN + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   truth,
  input  logic                 s_a,
  input  logic                 s_b,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [N_IN-1:0]      first_err_m,
  output logic                 first_err_valid,
  output logic                 a_err_seen,
  output logic                 b_err_seen,
  output logic                 smp_valid,
  output logic [N_IN-1:0]      smp_m,
  output logic                 smp_a,
  output logic                 smp_b
);

  localparam int unsigned     NM     = nmint(N_IN);
  localparam int              SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] M_LAST = N_IN'(NM - 1);
  localparam logic [SW-1:0]   S_LAST = SW'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [N_IN-1:0]    m_q, m_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [2**N_IN-1:0] truth_q, truth_d;
  logic               pass_q, pass_d;
  logic               clear;
  logic               ea, eb;

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    settle_d = settle_q;
    truth_d  = truth_q;
    pass_d   = pass_q;
    clear    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          truth_d  = truth;
          m_d      = '0;
          settle_d = '0;
          pass_d   = 1'b0;
          clear    = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == S_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        // m holds at the last minterm so vec stays stable through DONE.
        if (m_q == M_LAST) begin
          state_d = ST_DONE;
        end else begin
          m_d     = m_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        pass_d  = (err_cnt == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      settle_q <= '0;
      truth_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      settle_q <= settle_d;
      truth_q  <= truth_d;
      pass_q   <= pass_d;
    end
  end

  assign ea = (s_a != truth_q[m_q]);
  assign eb = (s_b != truth_q[m_q]);

  tts_err_accum #(
    .N_IN  (N_IN),
    .ERR_W (ERR_W)
  ) u_err_accum (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .smp             (smp_valid),
    .m               (m_q),
    .ea              (ea),
    .eb              (eb),
    .err_cnt         (err_cnt),
    .first_err_m     (first_err_m),
    .first_err_valid (first_err_valid),
    .a_err_seen      (a_err_seen),
    .b_err_seen      (b_err_seen)
  );

  // pass is presented together with the done pulse, then held until next start.
  assign vec       = m_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = done ? (err_cnt == '0) : pass_q;
  assign smp_valid = (state_q == ST_SAMPLE);
  assign smp_m     = smp_valid ? m_q : '0;
  assign smp_a     = smp_valid & s_a;
  assign smp_b     = smp_valid & s_b;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 2-input and a 3-input instance, table-driven
// sweeps plus restart, reset-abort and latched-truth sequences.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 2-input instance, unit s = a | ~b (truth 4'b1101) with fault modes
  logic       start2 = 1'b0;
  logic [3:0] truth2 = 4'h0;
  logic       mode_a = 1'b0;
  logic       mode_b = 1'b0;
  logic       s_a2, s_b2;
  logic [1:0] vec2, first_err_m2, smp_m2;
  logic [2:0] err_cnt2;
  logic       busy2, done2, pass2, fv2, ae2, be2, smp_valid2, smp_a2, smp_b2;

  always_comb begin
    s_a2 = mode_a ? (vec2[1] & ~vec2[0]) : (vec2[1] | ~vec2[0]);
    s_b2 = mode_b ? 1'b0 : (vec2[1] | ~vec2[0]);
  end

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .truth(truth2), .s_a(s_a2), .s_b(s_b2),
    .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .first_err_m(first_err_m2), .first_err_valid(fv2), .a_err_seen(ae2),
    .b_err_seen(be2), .smp_valid(smp_valid2), .smp_m(smp_m2), .smp_a(smp_a2),
    .smp_b(smp_b2)
  );

  // 3-input instance, unit output = vec[2]
  logic       start3 = 1'b0;
  logic [7:0] truth3 = 8'h00;
  logic       s3;
  logic [2:0] vec3, first_err_m3, smp_m3;
  logic [3:0] err_cnt3;
  logic       busy3, done3, pass3, fv3, ae3, be3, smp_valid3, smp_a3, smp_b3;

  assign s3 = vec3[2];

  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .truth(truth3), .s_a(s3), .s_b(s3),
    .vec(vec3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
    .first_err_m(first_err_m3), .first_err_valid(fv3), .a_err_seen(ae3),
    .b_err_seen(be3), .smp_valid(smp_valid3), .smp_m(smp_m3), .smp_a(smp_a3),
    .smp_b(smp_b3)
  );

  // View of whichever instance is currently being swept
  logic       sel3 = 1'b0;
  logic       c_done, c_busy, c_pass, c_sv, c_sa, c_sb, c_fv, c_ae, c_be;
  logic [7:0] c_vec, c_sm, c_err, c_fm;

  always_comb begin
    if (sel3) begin
      c_done = done3; c_busy = busy3; c_pass = pass3; c_sv = smp_valid3;
      c_sa = smp_a3; c_sb = smp_b3; c_fv = fv3; c_ae = ae3; c_be = be3;
      c_vec = 8'(vec3); c_sm = 8'(smp_m3); c_err = 8'(err_cnt3); c_fm = 8'(first_err_m3);
    end else begin
      c_done = done2; c_busy = busy2; c_pass = pass2; c_sv = smp_valid2;
      c_sa = smp_a2; c_sb = smp_b2; c_fv = fv2; c_ae = ae2; c_be = be2;
      c_vec = 8'(vec2); c_sm = 8'(smp_m2); c_err = 8'(err_cnt2); c_fm = 8'(first_err_m2);
    end
  end

  typedef struct packed {
    logic [7:0] m;
    logic       a;
    logic       b;
  } smp_t;
  smp_t sbq[$];

  typedef struct {
    logic [3:0] tr;
    logic       ma;
    logic       mb;
    int         err;
    int         fm;
    logic       fv;
    logic       ae;
    logic       be;
    logic       ps;
  } row_t;
  row_t rows[5];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Runs one sweep; returns the edge count (after the accepting edge) at which
  // done was first seen, -1 if never, and the pass value seen with done.
  task automatic sweep(input logic use3, input logic [7:0] tr, input int restart_k,
                       input int rst_k, input int toggle_k, input logic stop_at_done,
                       output int done_k, output logic pass_at_done);
    int   nm, st, lim, ndone, ev;
    logic aborted;
    smp_t e;
    sel3 = use3;
    nm = use3 ? 8 : 4;
    st = use3 ? 3 : 1;
    lim = nm * (st + 1);
    ndone = 0;
    aborted = 1'b0;
    done_k = -1;
    pass_at_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (use3) begin start3 = 1'b1; truth3 = tr; end
    else begin start2 = 1'b1; truth2 = tr[3:0]; end
    @(posedge clk);
    #1;
    start2 = 1'b0;
    start3 = 1'b0;
    sbq.delete();
    for (int m = 0; m < nm; m++) begin
      e.m = 8'(m);
      if (use3) begin
        e.a = m[2];
        e.b = m[2];
      end else begin
        e.a = mode_a ? (m[1] & ~m[0]) : (m[1] | ~m[0]);
        e.b = mode_b ? 1'b0 : (m[1] | ~m[0]);
      end
      sbq.push_back(e);
    end
    for (int k = 0; k <= lim + 4; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      if (k == restart_k) begin
        if (use3) start3 = 1'b1; else start2 = 1'b1;
      end else begin
        start2 = 1'b0;
        start3 = 1'b0;
      end
      if (k == toggle_k) begin
        if (use3) truth3 = ~tr; else truth2 = ~tr[3:0];
      end
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        chk("abort_busy", c_busy, 0);
        chk("abort_vec", c_vec, 0);
        chk("abort_err", c_err, 0);
        aborted = 1'b1;
        sbq.delete();
      end else if (rst) begin
        rst = 1'b0;
      end
      if (k == 0) begin
        chk("start_clear_err", {c_err, c_fv, c_ae, c_be, c_pass}, 0);
      end
      if (!aborted) begin
        ev = k / (st + 1);
        if (ev > nm - 1) ev = nm - 1;
        if (k <= lim) chk("vec_busy", {c_vec, c_busy}, {8'(ev), 1'b1});
        else chk("idle_busy", c_busy, 0);
      end
      if (c_sv) begin
        if (sbq.size() == 0) begin
          chk("unexpected_sample", c_sm, 8'hFF);
        end else begin
          e = sbq.pop_front();
          chk("smp_m", c_sm, e.m);
          chk("smp_ab", {c_sa, c_sb}, {e.a, e.b});
        end
      end
      if (c_done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          pass_at_done = c_pass;
        end
        if (stop_at_done) break;
      end
    end
    if (!aborted) begin
      chk("samples_left", sbq.size(), 0);
      if (!stop_at_done) chk("done_count", ndone, 1);
    end
    start2 = 1'b0;
    start3 = 1'b0;
    $display("sweep n_in=%0d truth=%h done_cycle=%0d err=%0d first=%0d/%0b a=%0b b=%0b pass=%0b",
             use3 ? 3 : 2, tr, done_k + 1, c_err, c_fm, c_fv, c_ae, c_be, pass_at_done);
  endtask

  int   dk;
  logic pd;

  initial begin
    rows[0] = '{4'b1101, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    rows[1] = '{4'b1101, 1'b0, 1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    rows[2] = '{4'b1101, 1'b1, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    rows[3] = '{4'b1101, 1'b1, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    rows[4] = '{4'b0101, 1'b0, 1'b0, 1, 3, 1'b1, 1'b1, 1'b1, 1'b0};

    #1 rst = 1'b1;
    #1;
    chk("rst_busy_done_pass", {busy2, done2, pass2, busy3, done3, pass3}, 0);
    chk("rst_vec", {vec2, vec3}, 0);
    chk("rst_err", {err_cnt2, err_cnt3}, 0);
    chk("rst_first", {first_err_m2, fv2, first_err_m3, fv3}, 0);
    chk("rst_seen", {ae2, be2, ae3, be3}, 0);
    chk("rst_smp", {smp_valid2, smp_m2, smp_a2, smp_b2, smp_valid3, smp_m3, smp_a3, smp_b3}, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (rows[i]) begin
      mode_a = rows[i].ma;
      mode_b = rows[i].mb;
      sweep(1'b0, 8'(rows[i].tr), -1, -1, -1, 1'b0, dk, pd);
      chk("done_cycle", dk, 8);
      chk("err_cnt", c_err, rows[i].err);
      chk("first_err", {c_fv, c_fm}, {rows[i].fv, 8'(rows[i].fm)});
      chk("err_seen", {c_ae, c_be}, {rows[i].ae, rows[i].be});
      chk("pass_at_done", pd, rows[i].ps);
      chk("pass_held", c_pass, rows[i].ps);
    end

    // start re-pulsed at cycle 4 is ignored; single done at cycle 9
    mode_a = 1'b0;
    mode_b = 1'b0;
    sweep(1'b0, 8'h0D, 3, -1, -1, 1'b0, dk, pd);
    chk("repulse_done_cycle", dk, 8);
    chk("repulse_pass", pd, 1);

    // failing sweep, then a start in the IDLE cycle right after DONE
    mode_b = 1'b1;
    sweep(1'b0, 8'h0D, -1, -1, -1, 1'b1, dk, pd);
    chk("b2b_first_done", dk, 8);
    chk("b2b_first_err", c_err, 3);
    mode_b = 1'b0;
    sweep(1'b0, 8'h0D, -1, -1, -1, 1'b1, dk, pd);
    chk("b2b_second_done", dk, 8);
    chk("b2b_second_err", {c_err, c_fv, c_ae, c_be}, 0);
    chk("b2b_second_pass", pd, 1);

    // reset at cycle 5 aborts the sweep with no done pulse
    mode_b = 1'b1;
    sweep(1'b0, 8'h0D, -1, 4, -1, 1'b0, dk, pd);
    chk("abort_no_done", dk, -1);
    chk("abort_pass", c_pass, 0);
    mode_b = 1'b0;
    sweep(1'b0, 8'h0D, -1, -1, -1, 1'b0, dk, pd);
    chk("after_abort_done", dk, 8);
    chk("after_abort_pass", pd, 1);

    // wider instance with truth toggled mid-sweep
    sweep(1'b1, 8'hF0, -1, -1, 10, 1'b0, dk, pd);
    chk("n3_done_cycle", dk, 32);
    chk("n3_pass", pd, 1);
    chk("n3_err", {c_err, c_fv}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
